// File: rtl/puf_key_collector.sv
// PUF key collector: sweeps four challenges, majority-votes each response bit,
// and assembles a 32-bit device key plus a per-bit instability mask.
module puf_key_collector #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        puf_enable,
  output logic [1:0]  puf_challenge,
  input  logic [7:0]  puf_response,
  output logic        busy,
  output logic        done,
  output logic        key_valid,
  output logic [31:0] key,
  output logic [31:0] unstable_mask,
  output logic        key_unstable
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam int MAXC =
    (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF = CW'(NUM_SAMPLES / 2);
  localparam logic [CW-1:0] FULL = CW'(NUM_SAMPLES);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] SMP_LAST = TW'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    STORE,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [1:0]      chal;
  logic [TW-1:0]   timer;
  logic [7:0]      sync1;
  logic [7:0]      sync2;
  logic [CW-1:0]   cnt [8];
  logic [7:0]      vote;
  logic [7:0]      unst;
  logic            accept;
  logic            kill;
  logic            store_ok;

  assign puf_enable    = (state == SETTLE) || (state == SAMPLE);
  assign busy          = puf_enable || (state == STORE);
  assign done          = (state == DONE);
  assign puf_challenge = chal;
  assign key_unstable  = |unstable_mask;

  // Next-state decode; abort wins over every busy-state transition.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    kill     = 1'b0;
    store_ok = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          accept  = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n = IDLE;
          kill    = 1'b1;
        end else if (timer == SET_LAST) begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_n = IDLE;
          kill    = 1'b1;
        end else if (timer == SMP_LAST) begin
          state_n = STORE;
        end
      end
      STORE: begin
        if (abort) begin
          state_n = IDLE;
          kill    = 1'b1;
        end else begin
          store_ok = 1'b1;
          state_n  = (chal == 2'd3) ? DONE : SETTLE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Majority vote and disagreement flag per response bit.
  always_comb begin
    vote = '0;
    unst = '0;
    for (int i = 0; i < 8; i++) begin
      vote[i] = cnt[i] > HALF;
      unst[i] = (cnt[i] != '0) && (cnt[i] != FULL);
    end
  end

  // State, phase timer and challenge index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      chal  <= '0;
    end else begin
      state <= state_n;
      if ((state_n != state) || !puf_enable) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
      if (accept || kill) begin
        chal <= '0;
      end else if (store_ok) begin
        chal <= chal + 2'd1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous PUF response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= puf_response;
      sync2 <= sync1;
    end
  end

  // Per-bit ones counters accumulated over the sample window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept || kill || store_ok) begin
          cnt[i] <= '0;
        end else if ((state == SAMPLE) && sync2[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Key, mask and valid flag; cleared on accept or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key           <= '0;
      unstable_mask <= '0;
      key_valid     <= 1'b0;
    end else if (accept || kill) begin
      key           <= '0;
      unstable_mask <= '0;
      key_valid     <= 1'b0;
    end else if (store_ok) begin
      key[{chal, 3'b000} +: 8]           <= vote;
      unstable_mask[{chal, 3'b000} +: 8] <= unst;
      if (chal == 2'd3) key_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_puf_key_collector.sv
// Directed bench for puf_key_collector with a table-driven PUF model
// and per-cycle bit flips to exercise the majority vote.
module tb_puf_key_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        puf_enable;
  logic [1:0]  puf_challenge;
  logic [7:0]  puf_response;
  logic        busy;
  logic        done;
  logic        key_valid;
  logic [31:0] key;
  logic [31:0] unstable_mask;
  logic        key_unstable;

  logic [7:0]  tbl [4];
  logic [7:0]  flip = 8'h00;
  logic [7:0]  flip_tbl [64];
  logic        en_log [64];
  logic [1:0]  ch_log [64];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          dc;
  int          n;
  int          d1;
  int          d2;

  puf_key_collector #(
    .SETTLE_CYCLES(4),
    .NUM_SAMPLES(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .puf_enable(puf_enable),
    .puf_challenge(puf_challenge),
    .puf_response(puf_response),
    .busy(busy),
    .done(done),
    .key_valid(key_valid),
    .key(key),
    .unstable_mask(unstable_mask),
    .key_unstable(key_unstable)
  );

  always #5 clk = ~clk;

  assign puf_response =
    puf_enable ? (tbl[puf_challenge] ^ flip) : 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    flip = (cyc < 64) ? flip_tbl[cyc] : 8'h00;
  endtask

  task automatic clr_flip();
    for (int i = 0; i < 64; i++) flip_tbl[i] = 8'h00;
  endtask

  task automatic run(output int d);
    d = -1;
    cyc = 0;
    flip = flip_tbl[0];
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 60 && d < 0) begin
      en_log[cyc] = puf_enable;
      ch_log[cyc] = puf_challenge;
      if (done) d = cyc;
      else step();
    end
  endtask

  initial begin
    clr_flip();
    tbl[0] = 8'hA5;
    tbl[1] = 8'h3C;
    tbl[2] = 8'hFF;
    tbl[3] = 8'h00;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ctl",
          {busy, done, puf_enable, puf_challenge, key_valid, key_unstable},
          32'h0);
    check("reset key", key, 32'h0);
    check("reset mask", unstable_mask, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    run(dc);
    check("run1 done cycle", dc, 41);
    check("run1 key", key, 32'h00FF3CA5);
    check("run1 mask", unstable_mask, 32'h0);
    check("run1 valid/busy", {key_valid, busy}, 2'b10);
    check("run1 challenges",
          {ch_log[1], ch_log[11], ch_log[21], ch_log[31], ch_log[39]},
          10'b00_01_10_11_11);
    check("run1 enable",
          {en_log[9], en_log[10], en_log[11], en_log[20], en_log[30],
           en_log[40]},
          6'b101000);
    step();
    check("idle after done", {key_valid, done, busy, puf_enable}, 4'b1000);

    clr_flip();
    flip_tbl[13] = 8'h01;
    flip_tbl[14] = 8'h01;
    flip_tbl[16] = 8'h01;
    run(dc);
    check("vote 11010 cycle", dc, 41);
    check("vote 11010 key", key, 32'h00FF3DA5);
    check("vote 11010 mask", unstable_mask, 32'h00000100);
    check("vote 11010 unstable", key_unstable, 1'b1);
    step();

    clr_flip();
    flip_tbl[13] = 8'h01;
    flip_tbl[16] = 8'h01;
    run(dc);
    check("vote 10010 key", key, 32'h00FF3CA5);
    check("vote 10010 mask", unstable_mask, 32'h00000100);
    step();
    clr_flip();

    cyc = 0;
    dc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 60 && dc < 0) begin
      if (done) begin
        dc = cyc;
      end else begin
        if (cyc == 20) start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    check("busy pulse cycle", dc, 41);
    check("busy pulse key", key, 32'h00FF3CA5);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start in done c42", busy, 1'b0);
    step();
    check("start in done c43", {busy, key_valid}, 2'b01);

    cyc = 0;
    n = 0;
    d1 = -1;
    d2 = -1;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (done) begin
        n++;
        if (n == 1) d1 = cyc;
        if (n == 2) d2 = cyc;
      end
    end
    start = 1'b0;
    check("held start dones", n, 2);
    check("held start first", d1, 41);
    check("held start second", d2, 83);
    while (!done && cyc < 200) step();
    check("held start tail done", done, 1'b1);
    check("held start key", key, 32'h00FF3CA5);
    step();

    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 15) step();
    check("pre-abort key", key, 32'h000000A5);
    check("pre-abort valid", key_valid, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort ctl",
          {busy, done, puf_enable, puf_challenge, key_valid}, 6'h0);
    check("abort key", key, 32'h0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done) n++;
    end
    check("abort no done", n, 0);
    run(dc);
    check("post-abort cycle", dc, 41);
    check("post-abort key", key, 32'h00FF3CA5);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort in idle", {key_valid, key}, {1'b1, 32'h00FF3CA5});

    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 24) step();
    check("pre-reset key", key, 32'h00003CA5);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid reset ctl",
          {busy, done, puf_enable, puf_challenge, key_valid, key_unstable},
          32'h0);
    check("mid reset key", key, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    run(dc);
    check("post-reset cycle", dc, 41);
    check("post-reset key", key, 32'h00FF3CA5);
    step();

    flip_tbl[13] = 8'h01;
    flip_tbl[14] = 8'h01;
    flip_tbl[16] = 8'h01;
    run(dc);
    check("b2b first mask", unstable_mask, 32'h00000100);
    step();
    clr_flip();
    tbl[0] = 8'h12;
    tbl[1] = 8'h34;
    tbl[2] = 8'h56;
    tbl[3] = 8'h78;
    cyc = 0;
    dc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b accept clear",
          {key_valid, key_unstable, key | unstable_mask}, 34'h0);
    while (cyc < 60 && dc < 0) begin
      if (done) dc = cyc;
      else step();
    end
    check("b2b cycle", dc, 41);
    check("b2b key", key, 32'h78563412);
    check("b2b mask", {key_unstable, unstable_mask}, 33'h0);
    check("b2b valid", key_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
